// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU.
// Logical, arithmetic and compare ops finish in one cycle; shifts run
// bit-serially, one bit per cycle. Ready/valid on both sides lets the
// pipeline stall around the multi-cycle shifts.
//
// state | meaning
// IDLE  | no result held, ready for a request
// SHIFT | bit-serial shift in progress, request side stalled
// DONE  | result/zero presented with out_valid, waiting for out_ready
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_BNE = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_SLT = 4'b1100;
    localparam logic [3:0] OP_BGE = 4'b1101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_reg;
    logic [WIDTH-1:0] sh_next;
    logic [SHW-1:0]   cnt;
    logic [3:0]       sh_op;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   amt;
    logic             is_shift;
    logic             start_shift;
    logic             last_shift;
    logic             accept;

    assign amt         = b[SHW-1:0];
    assign is_shift    = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    // A zero-amount shift is just a pass-through of a, handled as a one-cycle op.
    assign start_shift = is_shift && (amt != '0);
    assign last_shift  = (cnt == SHW'(1));
    assign accept      = in_valid && in_ready;

    // Single-cycle result for every non-shift op (and zero-amount shifts).
    always_comb begin
        alu_res = '0;
        case (op)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_ADD: alu_res = a + b;
            OP_XOR: alu_res = a ^ b;
            OP_SUB: alu_res = a - b;
            OP_BNE: alu_res = {{(WIDTH-1){1'b0}}, (a != b)};
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_BGE: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) >= $signed(b))};
            OP_SLL, OP_SRL, OP_SRA: alu_res = a;
            default: alu_res = '0;
        endcase
    end

    // One-bit shift step for the serial shifter.
    always_comb begin
        sh_next = sh_reg;
        case (sh_op)
            OP_SLL:  sh_next = {sh_reg[WIDTH-2:0], 1'b0};
            OP_SRL:  sh_next = {1'b0, sh_reg[WIDTH-1:1]};
            OP_SRA:  sh_next = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
            default: sh_next = sh_reg;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides both accept and shift completion.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) state_nxt = start_shift ? SHIFT : DONE;
                end
                SHIFT: begin
                    if (last_shift) state_nxt = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        if (accept) state_nxt = start_shift ? SHIFT : DONE;
                        else        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Handshake outputs; out_ready -> in_ready is the only comb input path.
    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid = (state == DONE);
    end

    // Datapath: operand capture, serial shift, and result/zero registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_reg <= '0;
            cnt    <= '0;
            sh_op  <= '0;
            result <= '0;
            zero   <= 1'b0;
        end else if (!flush) begin
            if (accept) begin
                if (start_shift) begin
                    sh_reg <= a;
                    cnt    <= amt;
                    sh_op  <= op;
                end else begin
                    result <= alu_res;
                    zero   <= (alu_res == '0);
                end
            end else if (state == SHIFT) begin
                sh_reg <= sh_next;
                cnt    <= cnt - SHW'(1);
                if (last_shift) begin
                    result <= sh_next;
                    zero   <= (sh_next == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with a queue-based scoreboard: the driver
// pushes the hand-computed result on each accept, the monitor pops and
// compares on every output transfer.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int tests = 0;
    int fails = 0;
    logic [32:0] exp_q[$];

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge when valid & ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [32:0] e;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got 0x%08h expected no output", result);
            end else begin
                e = exp_q.pop_front();
                check("sb_result", result, e[31:0]);
                check("sb_zero", {31'd0, zero}, {31'd0, e[32]});
            end
        end
    end

    // Present a request until accepted; optionally register the expected result.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input bit expect_out);
        int n;
        op = o; a = x; b = y; in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                tests++; fails++;
                $display("FAIL accept_timeout: got in_ready=0 expected 1");
                break;
            end
        end
        if (expect_out) exp_q.push_back({(r == 32'd0), r});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count negedges after accept until out_valid; return one edge after it.
    task automatic wait_valid(output int lat, output bit ready_low);
        lat = 0;
        ready_low = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && in_ready) ready_low = 1'b0;
        end while (!out_valid && lat < 100);
        @(posedge clk); #1;
    endtask

    task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] r, input int exp_lat);
        int lat;
        bit rl;
        issue(o, x, y, r, 1'b1);
        wait_valid(lat, rl);
        check({name, "_latency"}, lat, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        bit rl;
        bit ok;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 4'h0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_wrap", 4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1);
        run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 32'd0, 1);

        issue(4'b1010, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b1);
        wait_valid(lat, rl);
        check("sra31_latency", lat, 32);
        check("sra31_in_ready_low", {31'd0, rl}, 32'd1);

        run_op("srl31", 4'b0101, 32'h8000_0000, 32'd31, 32'h0000_0001, 32);
        run_op("sll0", 4'b0011, 32'd1, 32'd0, 32'h0000_0001, 1);
        run_op("sll4", 4'b0011, 32'd1, 32'd4, 32'h0000_0010, 5);
        run_op("sra4", 4'b1010, 32'hF000_0000, 32'd4, 32'hFF00_0000, 5);
        run_op("blt", 4'b1100, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        run_op("bge", 4'b1101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        run_op("bne_eq", 4'b1001, 32'd7, 32'd7, 32'd0, 1);
        run_op("bne_ne", 4'b1001, 32'd7, 32'd8, 32'd1, 1);
        run_op("op_f", 4'b1111, 32'h1234_5678, 32'h1, 32'd0, 1);
        run_op("or", 4'b0001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1);

        // Backpressure: XOR result held for 5 cycles, then released with AND pending.
        out_ready = 1'b0;
        issue(4'b0100, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b1);
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!out_valid || in_ready || result !== 32'h0000_FF00 || zero) ok = 1'b0;
        end
        check("bp_hold_stable", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(4'b0000, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b1);
        @(negedge clk);
        check("bp_and_next_cycle_valid", {31'd0, out_valid}, 32'd1);
        check("bp_and_result", result, 32'h0F00_0F00);
        @(posedge clk); #1;

        // Flush in the third cycle of a 10-bit SLL.
        issue(4'b0011, 32'd1, 32'd10, 32'd0, 1'b0);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_idle_ready", {31'd0, in_ready}, 32'd1);
        ok = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) ok = 1'b0;
        end
        check("flush_no_valid", {31'd0, ok}, 32'd1);
        check("flush_result_kept", result, 32'h0F00_0F00);
        @(posedge clk); #1;
        run_op("add_after_flush", 4'b0010, 32'd2, 32'd3, 32'd5, 1);

        // Asynchronous reset in the middle of a shift.
        issue(4'b1010, 32'h8000_0000, 32'd20, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_zero", {31'd0, zero}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("or_after_rst", 4'b0001, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
